// File: rtl/line_buffer_ctrl.sv
// Steers pixels round-robin into four line buffers and, once three lines are
// stored, reads three adjacent buffers in lockstep to form a 3x3 window.
module line_buffer_ctrl #(
    parameter int WIDTH = 640,
    parameter int CNTW  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixelIn,
    input  logic        pixelValid,
    input  logic        readEnable,
    input  logic [95:0] bufData,
    output logic [7:0]  bufPixel,
    output logic [3:0]  bufWrite,
    output logic [3:0]  bufRead,
    output logic [71:0] windowData,
    output logic        windowValid,
    output logic        lineDone,
    output logic        full
);

    localparam int POSW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [POSW-1:0] LAST_POS   = POSW'(WIDTH - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(4 * WIDTH);
    localparam logic [CNTW-1:0] READ_COUNT = CNTW'(3 * WIDTH);

    typedef enum logic {IDLE, READ} StateType;

    StateType         state, nextState;
    logic [1:0]       writeBuf, readBuf, midBuf, botBuf;
    logic [POSW-1:0]  writePos, readPos;
    logic [CNTW-1:0]  count;
    logic             lineDoneReg, lineEnd, accept;
    logic [23:0]      bufWin [4];

    for (genvar n = 0; n < 4; n++) begin : gWin
        assign bufWin[n] = bufData[24*n +: 24];
    end

    // Outputs are forced quiet while reset is held, even if state is stale.
    assign full       = rst && (count == FULL_COUNT);
    assign accept     = rst && pixelValid && !full;
    assign bufPixel   = pixelIn;
    assign bufWrite   = accept ? (4'b0001 << writeBuf) : 4'b0000;
    assign lineDone   = rst && lineDoneReg;
    assign midBuf     = readBuf + 2'd1;
    assign botBuf     = readBuf + 2'd2;
    assign windowData = {bufWin[readBuf], bufWin[midBuf], bufWin[botBuf]};

    always_comb begin
        nextState   = state;
        windowValid = 1'b0;
        bufRead     = 4'b0000;
        lineEnd     = 1'b0;
        case (state)
            IDLE: begin
                if (readEnable && count >= READ_COUNT) begin
                    nextState = READ;
                end
            end
            READ: begin
                windowValid     = rst;
                bufRead[readBuf] = rst;
                bufRead[midBuf]  = rst;
                bufRead[botBuf]  = rst;
                if (readPos == LAST_POS) begin
                    lineEnd   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A simultaneous accept and window read leaves the stored count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            writeBuf    <= 2'd0;
            writePos    <= '0;
            readBuf     <= 2'd0;
            readPos     <= '0;
            count       <= '0;
            lineDoneReg <= 1'b0;
        end else begin
            state       <= nextState;
            lineDoneReg <= lineEnd;
            if (accept) begin
                if (writePos == LAST_POS) begin
                    writePos <= '0;
                    writeBuf <= writeBuf + 2'd1;
                end else begin
                    writePos <= writePos + POSW'(1);
                end
            end
            if (windowValid) begin
                if (lineEnd) begin
                    readPos <= '0;
                    readBuf <= readBuf + 2'd1;
                end else begin
                    readPos <= readPos + POSW'(1);
                end
            end
            case ({accept, windowValid})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized directed bench for line_buffer_ctrl, checked every cycle against
// a running-total model of pixels written, windows read and stored count.
module tb_line_buffer_ctrl;

    localparam int W    = 8;
    localparam int CNTW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pixelIn = '0;
    logic        pixelValid = 1'b0;
    logic        readEnable = 1'b0;
    logic [95:0] bufData = '0;
    logic [7:0]  bufPixel;
    logic [3:0]  bufWrite, bufRead;
    logic [71:0] windowData;
    logic        windowValid, lineDone, full;

    int total = 0;
    int bad   = 0;

    // Model: totals since the last reset rather than pointers.
    int mCount = 0, mWr = 0, mRd = 0, mAccept = 0;
    bit mReading = 0, mDone = 0;
    logic eValid;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.WIDTH(W), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .pixelIn(pixelIn), .pixelValid(pixelValid),
        .readEnable(readEnable), .bufData(bufData), .bufPixel(bufPixel),
        .bufWrite(bufWrite), .bufRead(bufRead), .windowData(windowData),
        .windowValid(windowValid), .lineDone(lineDone), .full(full)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rowOf(input int b);
        return 24'(bufData >> (24 * b));
    endfunction

    task automatic checkOutput();
        int rb;
        logic eFull;
        logic [3:0] eWrite, eRead;
        rb      = (mRd / W) % 4;
        eFull   = rst && (mCount == 4 * W);
        mAccept = (rst && pixelValid && !eFull) ? 1 : 0;
        eWrite  = (mAccept != 0) ? 4'(1 << ((mWr / W) % 4)) : 4'b0000;
        eValid  = rst && mReading;
        eRead   = 4'b0000;
        if (eValid) begin
            eRead[rb] = 1'b1;
            eRead[(rb + 1) % 4] = 1'b1;
            eRead[(rb + 2) % 4] = 1'b1;
        end
        check("bufPixel", 96'(bufPixel), 96'(pixelIn));
        check("bufWrite", 96'(bufWrite), 96'(eWrite));
        check("bufRead", 96'(bufRead), 96'(eRead));
        check("windowValid", 96'(windowValid), 96'(eValid));
        check("lineDone", 96'(lineDone), 96'(rst && mDone));
        check("full", 96'(full), 96'(eFull));
        if (rst) check("count", 96'(dut.count), 96'(mCount));
        if (eValid)
            check("windowData", 96'(windowData),
                  96'({rowOf(rb), rowOf((rb + 1) % 4), rowOf((rb + 2) % 4)}));
    endtask

    task automatic updateModel();
        int oldCount;
        if (!rst) begin
            mCount = 0; mWr = 0; mRd = 0; mReading = 0; mDone = 0;
        end else begin
            oldCount = mCount;
            mCount   = mCount + mAccept - (eValid ? 1 : 0);
            mWr      = mWr + mAccept;
            if (mReading) begin
                mRd++;
                mDone = (mRd % W == 0);
                if (mDone) mReading = 0;
            end else begin
                mDone = 0;
                if (readEnable && oldCount >= 3 * W) mReading = 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic ren);
        @(negedge clk);
        rst        = r;
        pixelValid = v;
        readEnable = ren;
        pixelIn    = 8'($urandom);
        bufData    = {$urandom, $urandom, $urandom};
        #1;
        checkOutput();
        updateModel();
    endtask

    initial begin
        // Reset held with valid input: everything quiet.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

        // Fill all four buffers without reading; 33rd pixel is dropped.
        repeat (33) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        check("countHeldFull", 96'(dut.count), 96'(32));
        check("fullHeld", 96'(full), 96'(1));

        // Three lines then one full line read.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (24) applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (14) applyStimulus(1'b1, 1'b0, 1'b1);
        check("readBufAdvanced", 96'(dut.readBuf), 96'(1));

        // Continuous input over six lines.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (48) applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (30) applyStimulus(1'b1, 1'b0, 1'b1);

        // Reset during the 4th READ cycle, then refill.
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (24) applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        check("cntAfterRst", 96'(dut.count), 96'(0));
        check("readPosAfterRst", 96'(dut.readPos), 96'(0));
        repeat (24) applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b1);

        // Random traffic with occasional resets.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
